// File: rtl/code_loader.sv
// code_loader: boot loader that writes a length-prefixed, checksummed byte-stream image into code memory and holds the CPU in reset until it verifies
module code_loader #(
  parameter int CODE_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  reload,
  output logic                  code_we,
  output logic [CODE_WIDTH-1:0] code_addr,
  output logic [15:0]           code_data,
  output logic                  cpu_reset,
  output logic                  load_error
);
  typedef enum logic [2:0] {HDR_LO, HDR_HI, DAT_LO, DAT_HI, CHK_LO, CHK_HI, RUN} state_t;
  state_t                state_q;
  logic [15:0]           n_q, idx_q, sum_q, data_q;
  logic [7:0]            lo_q;
  logic                  over_q, we_q, rdy_q, cpu_rst_q, err_q;
  logic [CODE_WIDTH-1:0] addr_q;
  logic                  take, fits, pass;
  logic [15:0]           word_d, idx_d, sum_d;
  assign take   = rx_valid && rdy_q;
  assign word_d = {rx_data, lo_q};
  assign idx_d  = idx_q + 16'd1;
  assign sum_d  = sum_q + word_d;
  assign fits   = (idx_q >> CODE_WIDTH) == 16'd0;
  assign pass   = (word_d == sum_q) && !over_q;
  assign rx_ready   = rdy_q;
  assign code_we    = we_q;
  assign code_addr  = addr_q;
  assign code_data  = data_q;
  assign cpu_reset  = cpu_rst_q;
  assign load_error = err_q;
  // Byte-driven load FSM; reload outranks any byte handshaked in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HDR_LO;
      n_q       <= 16'd0;
      idx_q     <= 16'd0;
      sum_q     <= 16'd0;
      lo_q      <= 8'd0;
      over_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= 16'd0;
      rdy_q     <= 1'b1;
      cpu_rst_q <= 1'b1;
      err_q     <= 1'b0;
    end else if (reload) begin
      state_q   <= HDR_LO;
      idx_q     <= 16'd0;
      sum_q     <= 16'd0;
      over_q    <= 1'b0;
      we_q      <= 1'b0;
      rdy_q     <= 1'b1;
      cpu_rst_q <= 1'b1;
    end else begin
      we_q <= 1'b0;
      if (take) begin
        case (state_q)
          HDR_LO: begin
            lo_q    <= rx_data;
            state_q <= HDR_HI;
          end
          HDR_HI: begin
            n_q     <= word_d;
            idx_q   <= 16'd0;
            sum_q   <= 16'd0;
            over_q  <= 1'b0;
            state_q <= (word_d == 16'd0) ? CHK_LO : DAT_LO;
          end
          DAT_LO: begin
            lo_q    <= rx_data;
            state_q <= DAT_HI;
          end
          DAT_HI: begin
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            we_q    <= fits;
            over_q  <= over_q | !fits;
            state_q <= (idx_d == n_q) ? CHK_LO : DAT_LO;
            if (fits) begin
              addr_q <= idx_q[CODE_WIDTH-1:0];
              data_q <= word_d;
            end
          end
          CHK_LO: begin
            lo_q    <= rx_data;
            state_q <= CHK_HI;
          end
          CHK_HI: begin
            state_q   <= pass ? RUN : HDR_LO;
            rdy_q     <= !pass;
            cpu_rst_q <= !pass;
            err_q     <= !pass;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
